sssp_engine: RTL and testbench

//  Edge-centric SSSP scatter engine for one vertex partition of the graph accelerator.
//  - Loads a partition's vertex records into local storage.
//  - Streams 512-bit edge cachelines through it; emits relaxed-distance update

---
 rtl/sssp_engine.sv | 176 +++++++++++++++++
 tb/tb_sssp_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sssp_engine.sv
// Edge-centric SSSP scatter engine for one vertex partition.
// Vertex records are held in a flop array so that all eight edge lanes can look up
// their source vertex in the same cycle. Edge words flow through two register stages:
// stage 1 holds the lookup results and stage 2 holds the relaxed update word.
module sssp_engine #(
  parameter int unsigned VTX_DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] word_in,
  input  logic         word_in_valid,
  input  logic [31:0]  w_addr,
  input  logic [1:0]   control,
  input  logic [15:0]  current_level,
  input  logic         last_input_in,
  output logic [511:0] word_out,
  output logic         word_out_valid,
  output logic         done,
  output logic [31:0]  update_entry_count
);

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 64;
  localparam int unsigned IDX_W  = $clog2(VTX_DEPTH);
  localparam int unsigned DIST_W = 32;
  localparam int unsigned LVL_W  = 16;
  localparam int unsigned NODE_W = 24;
  localparam int unsigned WT_W   = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned POP_W  = 4;

  localparam logic [DIST_W-1:0] DIST_INF = 32'hFFFF_FFFF;
  localparam logic [DIST_W-1:0] DIST_SAT = 32'hFFFF_FFFE;
  localparam logic [1:0]        CTL_VTX  = 2'd1;
  localparam logic [1:0]        CTL_EDGE = 2'd2;

  // Vertex storage
  logic [VTX_DEPTH-1:0][DIST_W-1:0] dist_q, dist_d;
  logic [VTX_DEPTH-1:0][LVL_W-1:0]  lvl_q,  lvl_d;

  // Stage 1: lookup results per lane
  logic [LANES-1:0]             s1_act_q,  s1_act_d;
  logic [LANES-1:0][DIST_W-1:0] s1_dist_q, s1_dist_d;
  logic [LANES-1:0][WT_W-1:0]   s1_wt_q,   s1_wt_d;
  logic [LANES-1:0][NODE_W-1:0] s1_dst_q,  s1_dst_d;

  // Stage 2: registered outputs
  logic [511:0]     word_out_q, word_out_d;
  logic             out_vld_q,  out_vld_d;
  logic [CNT_W-1:0] count_q,    count_d;

  // End-of-stream delay line and sticky completion flag
  logic [1:0] last_q, last_d;
  logic       done_q, done_d;

  logic vtx_we;
  logic edge_acc;
  logic [LANES-1:0][LANE_W-1:0] lane_in;
  logic [LANES-1:0][IDX_W-1:0]  wr_idx;
  logic [LANES-1:0][IDX_W-1:0]  rd_idx;
  logic [LANES-1:0][32:0]       sum_c;
  logic [LANES-1:0][DIST_W-1:0] nd_c;
  logic [POP_W-1:0]             pop_c;

  assign vtx_we   = word_in_valid && (control == CTL_VTX);
  assign edge_acc = word_in_valid && (control == CTL_EDGE);
  assign lane_in  = word_in;

  // Per-lane write and read indices, wrapped to the local vertex depth
  always_comb begin
    wr_idx = '0;
    rd_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_idx[i] = IDX_W'(w_addr + 32'(i));
      rd_idx[i] = IDX_W'(lane_in[i][NODE_W-1:0]);
    end
  end

  // Vertex load: each lane writes its own entry
  always_comb begin
    dist_d = dist_q;
    lvl_d  = lvl_q;
    if (vtx_we) begin
      for (int i = 0; i < LANES; i++) begin
        dist_d[wr_idx[i]] = lane_in[i][DIST_W-1:0];
        lvl_d[wr_idx[i]]  = lane_in[i][DIST_W+LVL_W-1:DIST_W];
      end
    end
  end

  // Stage 1: look up source vertices and decide which lanes are active
  always_comb begin
    s1_act_d  = '0;
    s1_dist_d = '0;
    s1_wt_d   = '0;
    s1_dst_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_dist_d[i] = dist_q[rd_idx[i]];
      s1_wt_d[i]   = lane_in[i][LANE_W-1:LANE_W-WT_W];
      s1_dst_d[i]  = lane_in[i][2*NODE_W-1:NODE_W];
      s1_act_d[i]  = edge_acc
                     && (lane_in[i] != {LANE_W{1'b1}})
                     && (lvl_q[rd_idx[i]] == current_level)
                     && (dist_q[rd_idx[i]] != DIST_INF);
    end
  end

  // Stage 2: relax with a saturating add and assemble the update word
  always_comb begin
    sum_c      = '0;
    nd_c       = '0;
    pop_c      = '0;
    word_out_d = word_out_q;
    out_vld_d  = |s1_act_q;
    for (int i = 0; i < LANES; i++) begin
      sum_c[i] = {1'b0, s1_dist_q[i]} + 33'(s1_wt_q[i]);
      nd_c[i]  = (sum_c[i] > 33'(DIST_SAT)) ? DIST_SAT : sum_c[i][DIST_W-1:0];
      pop_c    = pop_c + POP_W'(s1_act_q[i]);
    end
    if (out_vld_d) begin
      for (int i = 0; i < LANES; i++) begin
        word_out_d[LANE_W*i +: LANE_W] = s1_act_q[i] ? {nd_c[i], 8'h00, s1_dst_q[i]}
                                                     : {LANE_W{1'b1}};
      end
    end
    count_d = count_q + CNT_W'(pop_c);
  end

  // Completion: lets edges accepted alongside the end marker drain first
  always_comb begin
    last_d = {last_q[0], last_input_in};
    done_d = done_q | last_q[1];
  end

  // Vertex storage registers; reset marks every vertex unreached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dist_q <= '1;
      lvl_q  <= '0;
    end else begin
      dist_q <= dist_d;
      lvl_q  <= lvl_d;
    end
  end

  // Pipeline, output and completion registers; reset aborts in-flight words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_act_q   <= '0;
      s1_dist_q  <= '0;
      s1_wt_q    <= '0;
      s1_dst_q   <= '0;
      word_out_q <= '0;
      out_vld_q  <= 1'b0;
      count_q    <= '0;
      last_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      s1_act_q   <= s1_act_d;
      s1_dist_q  <= s1_dist_d;
      s1_wt_q    <= s1_wt_d;
      s1_dst_q   <= s1_dst_d;
      word_out_q <= word_out_d;
      out_vld_q  <= out_vld_d;
      count_q    <= count_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign word_out           = word_out_q;
  assign word_out_valid     = out_vld_q;
  assign done               = done_q;
  assign update_entry_count = count_q;

endmodule

// File: tb/tb_sssp_engine.sv
// Self-checking bench for sssp_engine: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the scatter rules.
module tb_sssp_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] word_in;
  logic         word_in_valid;
  logic [31:0]  w_addr;
  logic [1:0]   control;
  logic [15:0]  current_level;
  logic         last_input_in;
  logic [511:0] word_out;
  logic         word_out_valid;
  logic         done;
  logic [31:0]  update_entry_count;

  sssp_engine #(.VTX_DEPTH(1024)) dut (
    .clk                (clk),
    .rst                (rst),
    .word_in            (word_in),
    .word_in_valid      (word_in_valid),
    .w_addr             (w_addr),
    .control            (control),
    .current_level      (current_level),
    .last_input_in      (last_input_in),
    .word_out           (word_out),
    .word_out_valid     (word_out_valid),
    .done               (done),
    .update_entry_count (update_entry_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  string       ph = "init";

  // Reference model state
  logic [31:0] m_dist [1024];
  logic [15:0] m_lvl  [1024];
  typedef struct {
    int          due;
    logic [511:0] w;
    int          n;
  } pend_t;
  pend_t        pq [$];
  logic [511:0] e_word;
  logic         e_valid;
  logic [31:0]  e_count;
  logic         e_done;
  int           done_at;
  int           pcnt = 0;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s:%s got=%0h exp=%0h", ph, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 1024; j++) begin
      m_dist[j] = 32'hFFFF_FFFF;
      m_lvl[j]  = 16'h0;
    end
    pq.delete();
    e_word  = '0;
    e_valid = 1'b0;
    e_count = '0;
    e_done  = 1'b0;
    done_at = -1;
  endtask

  // Apply the scatter rules to the inputs about to be sampled at posedge pcnt+1
  task automatic model_sample();
    logic [63:0]  lane;
    logic [511:0] w;
    logic [32:0]  nd;
    int           idx;
    int           n;
    if (!rst) return;
    if (word_in_valid && control == 2'd1) begin
      for (int i = 0; i < 8; i++) begin
        lane = word_in[64*i +: 64];
        idx  = int'((w_addr + 32'(i)) % 1024);
        m_dist[idx] = lane[31:0];
        m_lvl[idx]  = lane[47:32];
      end
    end else if (word_in_valid && control == 2'd2) begin
      n = 0;
      w = '0;
      for (int i = 0; i < 8; i++) begin
        lane = word_in[64*i +: 64];
        idx  = int'(lane[23:0]) % 1024;
        if (lane != 64'hFFFF_FFFF_FFFF_FFFF && m_lvl[idx] == current_level
            && m_dist[idx] != 32'hFFFF_FFFF) begin
          nd = {1'b0, m_dist[idx]} + 33'(lane[63:48]);
          if (nd > 33'h0_FFFF_FFFE) nd = 33'h0_FFFF_FFFE;
          w[64*i +: 64] = {nd[31:0], 8'h00, lane[47:24]};
          n++;
        end else begin
          w[64*i +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
      end
      if (n > 0) pq.push_back('{due: pcnt + 2, w: w, n: n});
    end
    if (last_input_in && done_at < 0) done_at = pcnt + 3;
  endtask

  task automatic check_outputs();
    check_val("valid", 512'(word_out_valid), 512'(e_valid));
    check_val("word",  word_out, e_word);
    check_val("count", 512'(update_entry_count), 512'(e_count));
    check_val("done",  512'(done), 512'(e_done));
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk);
    pcnt++;
    if (pq.size() > 0 && pq[0].due == pcnt) begin
      e_valid = 1'b1;
      e_word  = pq[0].w;
      e_count = e_count + 32'(pq[0].n);
      void'(pq.pop_front());
    end else begin
      e_valid = 1'b0;
    end
    if (done_at >= 0 && pcnt >= done_at) e_done = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [1:0] ctl, input logic v, input logic [31:0] addr,
                       input logic [511:0] w, input logic last);
    control       = ctl;
    word_in_valid = v;
    w_addr        = addr;
    word_in       = w;
    last_input_in = last;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(2'd0, 1'b0, 32'h0, '0, 1'b0);
  endtask

  function automatic logic [63:0] vlane(input logic [31:0] d, input logic [15:0] l);
    return {16'h0, l, d};
  endfunction

  function automatic logic [63:0] elane(input logic [23:0] s, input logic [23:0] d,
                                        input logic [15:0] wt);
    return {wt, d, s};
  endfunction

  task automatic random_phase(input int cycles);
    logic [511:0] w;
    logic [31:0]  d;
    int           r;
    for (int c = 0; c < cycles; c++) begin
      current_level = ($urandom_range(0, 3) == 0) ? 16'd4 : 16'd3;
      r = $urandom_range(0, 9);
      w = '0;
      if (r < 3) begin
        for (int i = 0; i < 8; i++) begin
          case ($urandom_range(0, 3))
            0:       d = 32'hFFFF_FFFF;
            1:       d = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            default: d = 32'($urandom_range(0, 100000));
          endcase
          w[64*i +: 64] = vlane(d, 16'($urandom_range(3, 5)));
        end
        drive(2'd1, 1'b1,
              ($urandom_range(0, 5) == 0) ? 32'd1020 :
              32'($urandom_range(0, 8) * 8 + $urandom_range(0, 3) * 1024),
              w, $urandom_range(0, 49) == 0);
      end else if (r < 8) begin
        for (int i = 0; i < 8; i++) begin
          if ($urandom_range(0, 7) == 0)
            w[64*i +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
          else
            w[64*i +: 64] = elane(24'($urandom_range(0, 75) + 1024 * $urandom_range(0, 3)),
                                  24'($urandom), 16'($urandom));
        end
        drive(2'd2, $urandom_range(0, 9) != 0, 32'h0, w, $urandom_range(0, 49) == 0);
      end else begin
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        drive(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, 1'b1, 32'h0, w, 1'b0);
      end
    end
  endtask

  logic [511:0] pad;
  logic [511:0] w;

  initial begin
    pad           = '1;
    rst           = 1'b0;
    word_in       = '0;
    word_in_valid = 1'b0;
    w_addr        = '0;
    control       = 2'd0;
    current_level = 16'd3;
    last_input_in = 1'b0;
    model_reset();

    ph = "reset";
    tick();
    tick();
    rst = 1'b1;
    idle(2);

    ph = "basic";
    w = pad;
    w[63:0] = vlane(32'd5, 16'd3);
    drive(2'd1, 1'b1, 32'd0, w, 1'b0);
    w = pad;
    w[63:0] = elane(24'd0, 24'd9, 16'd7);
    drive(2'd2, 1'b1, 32'd0, w, 1'b0);
    idle(3);

    ph = "level_miss";
    w = pad;
    w[63:0] = vlane(32'd5, 16'd2);
    drive(2'd1, 1'b1, 32'd0, w, 1'b0);
    w = pad;
    w[63:0] = elane(24'd0, 24'd9, 16'd7);
    drive(2'd2, 1'b1, 32'd0, w, 1'b0);
    idle(3);

    ph = "inf_sat";
    w = pad;
    w[127:64]  = vlane(32'hFFFF_FFFF, 16'd3);
    w[191:128] = vlane(32'hFFFF_FFF0, 16'd3);
    drive(2'd1, 1'b1, 32'd0, w, 1'b0);
    w = pad;
    w[63:0]   = elane(24'd1, 24'd11, 16'd1);
    w[127:64] = elane(24'd2, 24'd12, 16'h20);
    drive(2'd2, 1'b1, 32'd0, w, 1'b0);
    idle(3);

    ph = "burst_done";
    for (int i = 0; i < 8; i++) w[64*i +: 64] = vlane(32'(10 * i + 1), 16'd3);
    drive(2'd1, 1'b1, 32'd0, w, 1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) w[64*i +: 64] = elane(24'(i), 24'(100 + 8 * b + i), 16'(b + 1));
      drive(2'd2, 1'b1, 32'd0, w, 1'b0);
    end
    drive(2'd0, 1'b0, 32'd0, '0, 1'b1);
    idle(6);

    ph = "random_after_done";
    random_phase(250);
    idle(3);

    ph = "abort";
    for (int i = 0; i < 8; i++) w[64*i +: 64] = elane(24'(i), 24'(50 + i), 16'd3);
    current_level = 16'd3;
    drive(2'd2, 1'b1, 32'd0, w, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    idle(2);
    rst = 1'b1;
    idle(1);

    ph = "fresh";
    w = pad;
    w[63:0] = vlane(32'd5, 16'd3);
    drive(2'd1, 1'b1, 32'd0, w, 1'b0);
    w = pad;
    w[63:0]    = elane(24'd0, 24'd9, 16'd7);
    w[127:64]  = elane(24'd1, 24'd10, 16'd7);
    drive(2'd2, 1'b1, 32'd0, w, 1'b0);
    idle(3);

    ph = "random_fresh";
    random_phase(300);
    drive(2'd0, 1'b0, 32'd0, '0, 1'b1);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
